icache_mshr_ctrl: RTL and testbench

- Next-generation instruction-cache miss controller. Supports up to NUM_MSHR outstanding memory loads, tracked in a miss-status table. Previous controller allowed one.
- Sits between IF stage, external icache data/tag array (cachemem) and the tagged memory bus.
- Deduplicates misses across WAYS fetch lanes and in-flight entries.
- Issues at most one BUS_LOAD per cycle. Produces the cachemem write strobe when tagged data returns.

---
 rtl/icache_pkg.sv | 20 ++
 rtl/icache_mshr_pick.sv | 27 ++
 rtl/icache_mshr_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_icache_mshr_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared types for the instruction-cache miss controller: bus command
// encoding, block-address width and the miss-status table entry.
package icache_pkg;

  localparam int BLK_BITS  = 29;
  // Storage width of a memory transaction tag; must cover the top's MEM_TAG_BITS.
  localparam int MEM_TAG_W = 4;

  typedef enum logic [1:0] {
    BUS_NONE = 2'b00,
    BUS_LOAD = 2'b01
  } bus_cmd_e;

  typedef struct packed {
    logic                 valid;
    logic [MEM_TAG_W-1:0] mem_tag;
    logic [BLK_BITS-1:0]  blk;
  } mshr_entry_t;

endpackage

// File: rtl/icache_mshr_pick.sv
// Lowest-set-bit priority encoder: one-hot grant, binary index and found flag.
module icache_mshr_pick #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  output logic [N-1:0]  o_onehot,
  output logic [IW-1:0] o_idx,
  output logic          o_found
);

  // Scan high to low so the lowest requesting bit is the last writer.
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_found  = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_onehot    = '0;
        o_onehot[i] = 1'b1;
        o_idx       = IW'(i);
        o_found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/icache_mshr_ctrl.sv
// Instruction-cache miss controller tracking up to NUM_MSHR outstanding loads.
// Optional next-line prefetch is enabled by defining ICACHE_NEXTLINE_PREFETCH_EN.
module icache_mshr_ctrl
  import icache_pkg::*;
#(
  parameter int WAYS         = 2,
  parameter int NUM_MSHR     = 4,
  parameter int IDX_BITS     = 5,
  parameter int TAG_BITS     = 8,
  parameter int MEM_TAG_BITS = MEM_TAG_W
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [MEM_TAG_BITS-1:0]        Imem2proc_response,
  input  logic [MEM_TAG_BITS-1:0]        Imem2proc_tag,
  input  logic [WAYS-1:0][31:0]          proc2Icache_addr,
  input  logic [WAYS-1:0]                proc2Icache_en,
  input  logic [WAYS-1:0]                cachemem_valid,
`ifdef ICACHE_NEXTLINE_PREFETCH_EN
  input  logic                           pf_cachemem_valid,
  output logic [IDX_BITS-1:0]            pf_rd_idx,
  output logic [TAG_BITS-1:0]            pf_rd_tag,
`endif
  output logic [WAYS-1:0][IDX_BITS-1:0]  rd_idx,
  output logic [WAYS-1:0][TAG_BITS-1:0]  rd_tag,
  output logic [WAYS-1:0]                Icache_valid_out,
  output logic [1:0]                     proc2Imem_command,
  output logic [31:0]                    proc2Imem_addr,
  output logic                           wr_en,
  output logic [IDX_BITS-1:0]            wr_idx,
  output logic [TAG_BITS-1:0]            wr_tag,
  output logic                           mshr_full
);

  localparam int LW = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int MW = (NUM_MSHR > 1) ? $clog2(NUM_MSHR) : 1;

  // Handshake: BUS_LOAD is the request valid; a nonzero Imem2proc_response in the
  // same cycle is the accept, zero means retry next cycle. Tagged data returns
  // later with no backpressure.
  mshr_entry_t r_mshr [NUM_MSHR];

  logic [NUM_MSHR-1:0]           w_valid, w_free, w_ret_match, w_resp_dup;
  logic [NUM_MSHR-1:0]           w_free_oh, w_ret_oh;
  logic [MW-1:0]                 w_free_idx, w_ret_idx;
  logic                          w_free_found, w_ret_found;
  logic [WAYS-1:0][BLK_BITS-1:0] w_lane_blk;
  logic [WAYS-1:0]               w_cand, w_lane_oh;
  logic [LW-1:0]                 w_lane_idx;
  logic                          w_lane_found;
  logic [BLK_BITS-1:0]           w_dem_blk, w_ret_blk, w_issue_blk;
  logic                          w_dem_issue, w_issue, w_accept, w_resp_nz;
  logic                          w_unused;

  always_comb begin
    w_valid     = '0;
    w_ret_match = '0;
    w_resp_dup  = '0;
    for (int e = 0; e < NUM_MSHR; e++) begin
      w_valid[e]     = r_mshr[e].valid;
      w_ret_match[e] = r_mshr[e].valid && (Imem2proc_tag != '0) &&
                       (r_mshr[e].mem_tag == MEM_TAG_W'(Imem2proc_tag));
      w_resp_dup[e]  = r_mshr[e].valid &&
                       (r_mshr[e].mem_tag == MEM_TAG_W'(Imem2proc_response));
    end
  end
  assign w_free = ~w_valid;

  // A missing lane whose block is already in flight merges into that entry.
  always_comb begin
    w_lane_blk = '0;
    w_cand     = '0;
    for (int l = 0; l < WAYS; l++) begin
      w_lane_blk[l] = proc2Icache_addr[l][31:3];
      w_cand[l]     = proc2Icache_en[l] & ~cachemem_valid[l];
      for (int e = 0; e < NUM_MSHR; e++) begin
        if (r_mshr[e].valid && (r_mshr[e].blk == proc2Icache_addr[l][31:3])) w_cand[l] = 1'b0;
      end
    end
  end

  icache_mshr_pick #(.N(WAYS)) u_lane_pick (
    .i_req(w_cand), .o_onehot(w_lane_oh), .o_idx(w_lane_idx), .o_found(w_lane_found)
  );
  icache_mshr_pick #(.N(NUM_MSHR)) u_free_pick (
    .i_req(w_free), .o_onehot(w_free_oh), .o_idx(w_free_idx), .o_found(w_free_found)
  );
  icache_mshr_pick #(.N(NUM_MSHR)) u_ret_pick (
    .i_req(w_ret_match), .o_onehot(w_ret_oh), .o_idx(w_ret_idx), .o_found(w_ret_found)
  );

  always_comb begin
    w_dem_blk = '0;
    w_ret_blk = '0;
    for (int l = 0; l < WAYS; l++) if (w_lane_oh[l]) w_dem_blk = w_lane_blk[l];
    for (int e = 0; e < NUM_MSHR; e++) if (w_ret_oh[e]) w_ret_blk = r_mshr[e].blk;
  end

  assign w_dem_issue = w_lane_found && w_free_found;
  assign w_resp_nz   = (Imem2proc_response != '0);

`ifdef ICACHE_NEXTLINE_PREFETCH_EN
  logic                r_pf_pend;
  logic [BLK_BITS-1:0] r_pf_blk;
  logic                w_pf_hit, w_pf_issue, w_unused_pf;

  always_comb begin
    w_pf_hit = 1'b0;
    for (int e = 0; e < NUM_MSHR; e++) begin
      if (r_mshr[e].valid && (r_mshr[e].blk == r_pf_blk)) w_pf_hit = 1'b1;
    end
  end

  // At least two free entries, so one always stays available for demand.
  assign w_pf_issue  = !w_lane_found && r_pf_pend && !pf_cachemem_valid && !w_pf_hit &&
                       ((w_free & (w_free - NUM_MSHR'(1))) != '0);
  assign w_issue     = w_dem_issue | w_pf_issue;
  assign w_issue_blk = w_dem_issue ? w_dem_blk : r_pf_blk;
  assign pf_rd_idx   = r_pf_blk[IDX_BITS-1:0];
  assign pf_rd_tag   = r_pf_blk[IDX_BITS +: TAG_BITS];
  assign w_unused_pf = ^r_pf_blk[BLK_BITS-1:IDX_BITS+TAG_BITS];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pf_pend <= 1'b0;
      r_pf_blk  <= '0;
    end else if (w_dem_issue && w_resp_nz) begin
      r_pf_pend <= 1'b1;
      r_pf_blk  <= w_dem_blk + BLK_BITS'(1);
    end else if (r_pf_pend && ((w_pf_issue && w_resp_nz) || pf_cachemem_valid || w_pf_hit)) begin
      r_pf_pend <= 1'b0;
    end
  end
`else
  assign w_issue     = w_dem_issue;
  assign w_issue_blk = w_dem_blk;
`endif

  assign w_accept = w_issue && w_resp_nz;

  // Returning and allocated entries are disjoint: one is valid, the other free.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int e = 0; e < NUM_MSHR; e++) r_mshr[e] <= '0;
    end else begin
      for (int e = 0; e < NUM_MSHR; e++) begin
        if (w_ret_oh[e]) r_mshr[e].valid <= 1'b0;
        if (w_accept && w_free_oh[e]) begin
          r_mshr[e] <= '{valid: 1'b1, mem_tag: MEM_TAG_W'(Imem2proc_response), blk: w_issue_blk};
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && w_accept) assert (w_resp_dup == '0);
  end

  always_comb begin
    rd_idx = '0;
    rd_tag = '0;
    for (int l = 0; l < WAYS; l++) begin
      rd_idx[l] = proc2Icache_addr[l][3 +: IDX_BITS];
      rd_tag[l] = proc2Icache_addr[l][3+IDX_BITS +: TAG_BITS];
    end
  end

  assign Icache_valid_out  = proc2Icache_en & cachemem_valid;
  assign proc2Imem_command = w_issue ? BUS_LOAD : BUS_NONE;
  assign proc2Imem_addr    = w_issue ? {w_issue_blk, 3'b000} : 32'd0;
  assign wr_en             = w_ret_found;
  assign wr_idx            = w_ret_blk[IDX_BITS-1:0];
  assign wr_tag            = w_ret_blk[IDX_BITS +: TAG_BITS];
  assign mshr_full         = &w_valid;

  always_comb begin
    w_unused = ^{w_lane_idx, w_free_idx, w_ret_idx, w_ret_blk[BLK_BITS-1:IDX_BITS+TAG_BITS]};
    for (int l = 0; l < WAYS; l++) w_unused = w_unused ^ (^proc2Icache_addr[l][2:0]);
  end

endmodule

// File: tb/tb_icache_mshr_ctrl.sv
// Self-checking bench for icache_mshr_ctrl: directed scenarios plus a randomized
// run against a list-based model of the outstanding misses.
module tb_icache_mshr_ctrl;
  import icache_pkg::*;

  localparam int WAYS = 2, NUM_MSHR = 4, IDX_BITS = 5, TAG_BITS = 8, MTB = 4;
  localparam int OBS_W = 2 + 2 + 32 + 1 + IDX_BITS + TAG_BITS + 1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [MTB-1:0]                  Imem2proc_response, Imem2proc_tag;
  logic [WAYS-1:0][31:0]           proc2Icache_addr;
  logic [WAYS-1:0]                 proc2Icache_en, cachemem_valid;
  logic [WAYS-1:0][IDX_BITS-1:0]   rd_idx;
  logic [WAYS-1:0][TAG_BITS-1:0]   rd_tag;
  logic [WAYS-1:0]                 Icache_valid_out;
  logic [1:0]                      proc2Imem_command;
  logic [31:0]                     proc2Imem_addr;
  logic                            wr_en, mshr_full;
  logic [IDX_BITS-1:0]             wr_idx;
  logic [TAG_BITS-1:0]             wr_tag;
`ifdef ICACHE_NEXTLINE_PREFETCH_EN
  logic                            pf_cachemem_valid = 1'b1;
  logic [IDX_BITS-1:0]             pf_rd_idx;
  logic [TAG_BITS-1:0]             pf_rd_tag;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct { logic [28:0] blk; logic [MTB-1:0] tag; } ref_ent_t;
  ref_ent_t         ref_q[$];
  logic [OBS_W-1:0] exp_q[$];

  always #5 clock = ~clock;

  icache_mshr_ctrl dut (
    .clock(clock), .reset(reset),
    .Imem2proc_response(Imem2proc_response), .Imem2proc_tag(Imem2proc_tag),
    .proc2Icache_addr(proc2Icache_addr), .proc2Icache_en(proc2Icache_en),
    .cachemem_valid(cachemem_valid),
`ifdef ICACHE_NEXTLINE_PREFETCH_EN
    .pf_cachemem_valid(pf_cachemem_valid), .pf_rd_idx(pf_rd_idx), .pf_rd_tag(pf_rd_tag),
`endif
    .rd_idx(rd_idx), .rd_tag(rd_tag), .Icache_valid_out(Icache_valid_out),
    .proc2Imem_command(proc2Imem_command), .proc2Imem_addr(proc2Imem_addr),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_tag(wr_tag), .mshr_full(mshr_full)
  );

  task automatic drive(input logic [1:0] en, input logic [1:0] cv, input logic [31:0] a0,
                       input logic [31:0] a1, input logic [MTB-1:0] resp, input logic [MTB-1:0] tag);
    proc2Icache_en      = en;
    cachemem_valid      = cv;
    proc2Icache_addr[0] = a0;
    proc2Icache_addr[1] = a1;
    Imem2proc_response  = resp;
    Imem2proc_tag       = tag;
  endtask

  task automatic next_cycle;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    drive(2'b00, 2'b00, 32'd0, 32'd0, '0, '0);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    ref_q.delete();
  endtask

  function automatic bit tag_busy(input logic [MTB-1:0] t);
    foreach (ref_q[k]) if (ref_q[k].tag == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit blk_busy(input logic [28:0] b);
    foreach (ref_q[k]) if (ref_q[k].blk == b) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [MTB-1:0] free_tag();
    logic [MTB-1:0] t;
    for (int n = 0; n < 64; n++) begin
      t = MTB'($urandom_range(1, 15));
      if (!tag_busy(t)) return t;
    end
    return '0;
  endfunction

  task automatic test_reset;
    do_reset;
    @(negedge clock);
    checks++; if (proc2Imem_command !== BUS_NONE) begin errors++; $display("FAIL reset_cmd: got %0h want %0h", proc2Imem_command, BUS_NONE); end
    checks++; if (proc2Imem_addr !== 32'd0) begin errors++; $display("FAIL reset_addr: got %0h want 0", proc2Imem_addr); end
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %0b want 0", wr_en); end
    checks++; if (wr_idx !== 5'd0) begin errors++; $display("FAIL reset_wr_idx: got %0h want 0", wr_idx); end
    checks++; if (wr_tag !== 8'd0) begin errors++; $display("FAIL reset_wr_tag: got %0h want 0", wr_tag); end
    checks++; if (mshr_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b want 0", mshr_full); end
    next_cycle;
  endtask

  task automatic test_single_miss;
    do_reset;
    drive(2'b01, 2'b00, 32'h1000, 32'd0, 4'd3, 4'd0);
    @(negedge clock);
    checks++; if (proc2Imem_command !== BUS_LOAD) begin errors++; $display("FAIL single_cmd: got %0h want %0h", proc2Imem_command, BUS_LOAD); end
    checks++; if (proc2Imem_addr !== 32'h1000) begin errors++; $display("FAIL single_addr: got %0h want 1000", proc2Imem_addr); end
    next_cycle;
    drive(2'b01, 2'b00, 32'h1000, 32'd0, 4'd4, 4'd0);
    @(negedge clock);
    checks++; if (proc2Imem_command !== BUS_NONE) begin errors++; $display("FAIL single_merge_cmd: got %0h want %0h", proc2Imem_command, BUS_NONE); end
    next_cycle;
    drive(2'b00, 2'b00, 32'd0, 32'd0, 4'd0, 4'd3);
    @(negedge clock);
    checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL single_wr_en: got %0b want 1", wr_en); end
    checks++; if (wr_idx !== 5'h00) begin errors++; $display("FAIL single_wr_idx: got %0h want 0", wr_idx); end
    checks++; if (wr_tag !== 8'h10) begin errors++; $display("FAIL single_wr_tag: got %0h want 10", wr_tag); end
    next_cycle;
    drive(2'b01, 2'b00, 32'h1000, 32'd0, 4'd0, 4'd0);
    @(negedge clock);
    checks++; if (proc2Imem_command !== BUS_LOAD) begin errors++; $display("FAIL single_freed_cmd: got %0h want %0h", proc2Imem_command, BUS_LOAD); end
    next_cycle;
  endtask

  task automatic test_dedup;
    do_reset;
    drive(2'b11, 2'b00, 32'h2008, 32'h2008, 4'd1, 4'd0);
    @(negedge clock);
    checks++; if (proc2Imem_command !== BUS_LOAD) begin errors++; $display("FAIL dedup_cmd: got %0h want %0h", proc2Imem_command, BUS_LOAD); end
    checks++; if (proc2Imem_addr !== 32'h2008) begin errors++; $display("FAIL dedup_addr: got %0h want 2008", proc2Imem_addr); end
    next_cycle;
    drive(2'b11, 2'b00, 32'h2008, 32'h2008, 4'd2, 4'd0);
    @(negedge clock);
    checks++; if (proc2Imem_command !== BUS_NONE) begin errors++; $display("FAIL dedup_merge_cmd: got %0h want %0h", proc2Imem_command, BUS_NONE); end
    next_cycle;
    drive(2'b00, 2'b00, 32'd0, 32'd0, 4'd0, 4'd1);
    @(negedge clock);
    checks++; if ({wr_en, wr_idx, wr_tag} !== {1'b1, 5'h01, 8'h20}) begin errors++; $display("FAIL dedup_wr: got %0b/%0h/%0h want 1/1/20", wr_en, wr_idx, wr_tag); end
    next_cycle;
    drive(2'b11, 2'b01, 32'h2100, 32'h2200, 4'd0, 4'd0);
    @(negedge clock);
    checks++; if (proc2Imem_addr !== 32'h2200) begin errors++; $display("FAIL dedup_lane1_addr: got %0h want 2200", proc2Imem_addr); end
    checks++; if (Icache_valid_out !== 2'b01) begin errors++; $display("FAIL dedup_valid_out: got %0b want 01", Icache_valid_out); end
    next_cycle;
  endtask

  task automatic test_full;
    do_reset;
    for (int i = 0; i < 4; i++) begin
      drive(2'b01, 2'b00, 32'h4000 + 32'(i * 8), 32'd0, MTB'(i + 1), 4'd0);
      @(negedge clock);
      checks++; if (proc2Imem_addr !== 32'h4000 + 32'(i * 8)) begin errors++; $display("FAIL full_fill_addr%0d: got %0h want %0h", i, proc2Imem_addr, 32'h4000 + 32'(i * 8)); end
      next_cycle;
    end
    drive(2'b01, 2'b00, 32'h5000, 32'd0, 4'd5, 4'd0);
    @(negedge clock);
    checks++; if (mshr_full !== 1'b1) begin errors++; $display("FAIL full_flag: got %0b want 1", mshr_full); end
    checks++; if (proc2Imem_command !== BUS_NONE) begin errors++; $display("FAIL full_cmd: got %0h want %0h", proc2Imem_command, BUS_NONE); end
    checks++; if (Icache_valid_out !== 2'b00) begin errors++; $display("FAIL full_stall: got %0b want 00", Icache_valid_out); end
    next_cycle;
    drive(2'b01, 2'b00, 32'h5000, 32'd0, 4'd5, 4'd2);
    @(negedge clock);
    checks++; if ({wr_en, wr_idx, wr_tag} !== {1'b1, 5'h01, 8'h40}) begin errors++; $display("FAIL full_ret_wr: got %0b/%0h/%0h want 1/1/40", wr_en, wr_idx, wr_tag); end
    checks++; if (proc2Imem_command !== BUS_NONE) begin errors++; $display("FAIL full_same_cycle_cmd: got %0h want %0h", proc2Imem_command, BUS_NONE); end
    next_cycle;
    drive(2'b01, 2'b00, 32'h5000, 32'd0, 4'd5, 4'd0);
    @(negedge clock);
    checks++; if (mshr_full !== 1'b0) begin errors++; $display("FAIL full_after_ret_flag: got %0b want 0", mshr_full); end
    checks++; if ({proc2Imem_command, proc2Imem_addr} !== {BUS_LOAD, 32'h5000}) begin errors++; $display("FAIL full_fifth_issue: got %0h/%0h want 1/5000", proc2Imem_command, proc2Imem_addr); end
    next_cycle;
  endtask

  task automatic test_reject;
    logic [MTB-1:0] resps [3];
    resps = '{4'd0, 4'd0, 4'd5};
    do_reset;
    for (int i = 0; i < 3; i++) begin
      drive(2'b01, 2'b00, 32'h6000, 32'd0, resps[i], 4'd0);
      @(negedge clock);
      checks++; if ({proc2Imem_command, proc2Imem_addr} !== {BUS_LOAD, 32'h6000}) begin errors++; $display("FAIL reject_hold%0d: got %0h/%0h want 1/6000", i, proc2Imem_command, proc2Imem_addr); end
      next_cycle;
    end
    drive(2'b01, 2'b00, 32'h6000, 32'd0, 4'd6, 4'd0);
    @(negedge clock);
    checks++; if (proc2Imem_command !== BUS_NONE) begin errors++; $display("FAIL reject_merge_cmd: got %0h want %0h", proc2Imem_command, BUS_NONE); end
    next_cycle;
    drive(2'b01, 2'b00, 32'h6100, 32'd0, 4'd6, 4'd0);
    next_cycle;
    drive(2'b01, 2'b00, 32'h6200, 32'd0, 4'd7, 4'd0);
    next_cycle;
    drive(2'b00, 2'b00, 32'd0, 32'd0, 4'd0, 4'd5);
    @(negedge clock);
    checks++; if (mshr_full !== 1'b0) begin errors++; $display("FAIL reject_single_alloc: got full=%0b want 0", mshr_full); end
    checks++; if ({wr_en, wr_idx, wr_tag} !== {1'b1, 5'h00, 8'h60}) begin errors++; $display("FAIL reject_wr: got %0b/%0h/%0h want 1/0/60", wr_en, wr_idx, wr_tag); end
    next_cycle;
    drive(2'b00, 2'b00, 32'd0, 32'd0, 4'd0, 4'd5);
    @(negedge clock);
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reject_stale_tag: got %0b want 0", wr_en); end
    next_cycle;
  endtask

  task automatic test_return_merge;
    do_reset;
    drive(2'b01, 2'b00, 32'h7040, 32'd0, 4'd9, 4'd0);
    next_cycle;
    drive(2'b01, 2'b00, 32'h7040, 32'd0, 4'd10, 4'd9);
    @(negedge clock);
    checks++; if ({wr_en, proc2Imem_command} !== {1'b1, BUS_NONE}) begin errors++; $display("FAIL retmerge_wr_cmd: got %0b/%0h want 1/0", wr_en, proc2Imem_command); end
    next_cycle;
    drive(2'b01, 2'b01, 32'h7040, 32'd0, 4'd0, 4'd0);
    @(negedge clock);
    checks++; if ({Icache_valid_out, proc2Imem_command} !== {2'b01, BUS_NONE}) begin errors++; $display("FAIL retmerge_hit: got %0b/%0h want 01/0", Icache_valid_out, proc2Imem_command); end
    next_cycle;
  endtask

  task automatic test_mid_reset;
    do_reset;
    drive(2'b01, 2'b00, 32'h7800, 32'd0, 4'd7, 4'd0);
    next_cycle;
    do_reset;
    drive(2'b00, 2'b00, 32'd0, 32'd0, 4'd0, 4'd7);
    @(negedge clock);
    checks++; if ({wr_en, mshr_full} !== 2'b00) begin errors++; $display("FAIL midreset_late_tag: got wr_en=%0b full=%0b want 0/0", wr_en, mshr_full); end
    next_cycle;
  endtask

`ifdef ICACHE_NEXTLINE_PREFETCH_EN
  task automatic test_prefetch;
    do_reset;
    pf_cachemem_valid = 1'b0;
    drive(2'b01, 2'b00, 32'h3000, 32'd0, 4'd1, 4'd0);
    next_cycle;
    drive(2'b00, 2'b00, 32'd0, 32'd0, 4'd2, 4'd0);
    @(negedge clock);
    checks++; if ({proc2Imem_command, proc2Imem_addr} !== {BUS_LOAD, 32'h3008}) begin errors++; $display("FAIL pf_issue: got %0h/%0h want 1/3008", proc2Imem_command, proc2Imem_addr); end
    checks++; if (pf_rd_idx !== 5'h01) begin errors++; $display("FAIL pf_rd_idx: got %0h want 1", pf_rd_idx); end
    next_cycle;
    do_reset;
    pf_cachemem_valid = 1'b1;
    drive(2'b01, 2'b00, 32'h3000, 32'd0, 4'd1, 4'd0);
    next_cycle;
    drive(2'b00, 2'b00, 32'd0, 32'd0, 4'd2, 4'd0);
    @(negedge clock);
    checks++; if (proc2Imem_command !== BUS_NONE) begin errors++; $display("FAIL pf_suppressed: got %0h want 0", proc2Imem_command); end
    next_cycle;
  endtask
`endif

  task automatic test_random;
    logic [28:0]      pool [6];
    logic [28:0]      lb [2];
    logic [1:0]       en, cv, e_vo, e_cmd;
    logic [MTB-1:0]   resp, tag;
    logic [31:0]      e_addr;
    logic             e_wr, e_full;
    logic [4:0]       e_idx;
    logic [7:0]       e_tg;
    logic [28:0]      iblk;
    logic [OBS_W-1:0] obs, want;
    bit               cand, issue;
    int               ret_k, r;
    do_reset;
    foreach (pool[p]) pool[p] = 29'($urandom);
    for (int cyc = 0; cyc < 600; cyc++) begin
      en = 2'($urandom_range(0, 3));
      for (int l = 0; l < 2; l++) begin
        cv[l] = ($urandom_range(0, 3) == 0);
        lb[l] = pool[$urandom_range(0, 5)];
      end
      r = $urandom_range(0, 9);
      if (r < 4 && ref_q.size() > 0) tag = ref_q[$urandom_range(0, ref_q.size() - 1)].tag;
      else if (r < 6) tag = free_tag();
      else tag = '0;
      resp = ($urandom_range(0, 3) == 0) ? '0 : free_tag();

      cand = 1'b0;
      iblk = '0;
      for (int l = 0; l < 2; l++) begin
        if (!cand && en[l] && !cv[l] && !blk_busy(lb[l])) begin
          cand = 1'b1;
          iblk = lb[l];
        end
      end
      issue = cand && (ref_q.size() < NUM_MSHR);
      ret_k = -1;
      if (tag != '0) foreach (ref_q[k]) if (ref_q[k].tag == tag) ret_k = k;
      e_vo   = en & cv;
      e_cmd  = issue ? BUS_LOAD : BUS_NONE;
      e_addr = issue ? 32'(iblk) * 32'd8 : 32'd0;
      e_wr   = (ret_k >= 0);
      e_idx  = '0;
      e_tg   = '0;
      if (ret_k >= 0) begin
        e_idx = 5'(ref_q[ret_k].blk % 32);
        e_tg  = 8'((ref_q[ret_k].blk / 32) % 256);
      end
      e_full = (ref_q.size() == NUM_MSHR);
      exp_q.push_back({e_vo, e_cmd, e_addr, e_wr, e_idx, e_tg, e_full});

      drive(en, cv, {lb[0], 3'($urandom_range(0, 7))}, {lb[1], 3'($urandom_range(0, 7))}, resp, tag);
      @(negedge clock);
      obs  = {Icache_valid_out, proc2Imem_command, proc2Imem_addr, wr_en, wr_idx, wr_tag, mshr_full};
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL random_cycle%0d: got %0h want %0h (vo,cmd,addr,wr_en,idx,tag,full)", cyc, obs, want);
      end
      next_cycle;
      if (ret_k >= 0) ref_q.delete(ret_k);
      if (issue && resp != '0) ref_q.push_back('{iblk, resp});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_single_miss;
    test_dedup;
    test_full;
    test_reject;
    test_return_merge;
    test_mid_reset;
`ifdef ICACHE_NEXTLINE_PREFETCH_EN
    test_prefetch;
`endif
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
